// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU sequencer: opcodes, ALU select codes, FSM states.
// The multiply path is built only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

    localparam int unsigned SEQ_WIDTH = 24;
    localparam int unsigned OPC_W     = 3;
    localparam int unsigned ALUOP_W   = 2;

    localparam logic [OPC_W-1:0] OPC_AND  = 3'b000;
    localparam logic [OPC_W-1:0] OPC_OR   = 3'b001;
    localparam logic [OPC_W-1:0] OPC_ADD  = 3'b010;
    localparam logic [OPC_W-1:0] OPC_SUB  = 3'b011;
    localparam logic [OPC_W-1:0] OPC_SLT  = 3'b100;
    localparam logic [OPC_W-1:0] OPC_NOR  = 3'b101;
    localparam logic [OPC_W-1:0] OPC_MUL  = 3'b110;
    localparam logic [OPC_W-1:0] OPC_RSVD = 3'b111;

    localparam logic [ALUOP_W-1:0] ALUOP_AND  = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_OR   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef struct packed {
        logic               a_inv;
        logic               b_inv;
        logic               cin;
        logic [ALUOP_W-1:0] op;
    } alu_ctrl_t;

    // Only the arithmetic passes report the ALU carry-out.
    function automatic logic has_carry(input logic [OPC_W-1:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_SLT);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode to ALU control-pin translation.
module alu_ctrl_decode
    import alu_seq_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output alu_ctrl_t        ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OPC_AND: ctrl_o.op = ALUOP_AND;
            OPC_OR:  ctrl_o.op = ALUOP_OR;
            OPC_ADD: ctrl_o.op = ALUOP_ADD;
            OPC_SUB: ctrl_o = '{a_inv: 1'b0, b_inv: 1'b1, cin: 1'b1, op: ALUOP_ADD};
            OPC_SLT: ctrl_o = '{a_inv: 1'b0, b_inv: 1'b1, cin: 1'b1, op: ALUOP_LESS};
            OPC_NOR: ctrl_o = '{a_inv: 1'b1, b_inv: 1'b1, cin: 1'b0, op: ALUOP_AND};
            OPC_MUL: ctrl_o.op = ALUOP_ADD;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer driving the ripple ALU; single-pass ops plus an optional
// 24-step shift-add multiply built only when ALU_SEQ_MUL_EN is defined.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [OPC_W-1:0]   req_opcode_i,
    input  logic [WIDTH-1:0]   req_a_i,
    input  logic [WIDTH-1:0]   req_b_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [WIDTH-1:0]   resp_result_o,
    output logic               resp_carry_o,
    output logic               resp_zero_o,
    output logic [WIDTH-1:0]   alu_a_o,
    output logic [WIDTH-1:0]   alu_b_o,
    output logic               alu_a_invert_o,
    output logic               alu_b_invert_o,
    output logic               alu_cin_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    input  logic [WIDTH-1:0]   alu_result_i,
    input  logic               alu_carry_out_i
);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   opcode_q, opcode_d;
    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    alu_ctrl_t          ctrl_q, ctrl_d;
    alu_ctrl_t          req_ctrl;
    logic               accept;
    logic               req_mul;
    logic               req_rsvd;

    alu_ctrl_decode u_decode (
        .opcode_i (req_opcode_i),
        .ctrl_o   (req_ctrl)
    );

    assign accept = (state_q == ST_IDLE) && req_ready_q && req_valid_i;

`ifdef ALU_SEQ_MUL_EN
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_last;

    assign req_mul  = (req_opcode_i == OPC_MUL);
    assign req_rsvd = (req_opcode_i == OPC_RSVD);
    assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

    // Shift-add step: the ALU adds M into P whenever the current multiplier bit is set.
    always_comb begin
        p_d   = p_q;
        m_d   = m_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        if (accept && req_mul) begin
            p_d   = '0;
            m_d   = req_a_i;
            q_d   = req_b_i;
            cnt_d = '0;
        end else if (state_q == ST_MUL) begin
            if (q_q[0]) begin
                p_d = alu_result_i;
            end
            m_d   = m_q << 1;
            q_d   = q_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_q   <= '0;
            m_q   <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            p_q   <= p_d;
            m_q   <= m_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end
`else
    assign req_mul  = 1'b0;
    assign req_rsvd = (req_opcode_i == OPC_RSVD) || (req_opcode_i == OPC_MUL);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_mul)       state_d = ST_MUL;
                    else if (req_rsvd) state_d = ST_DONE;
                    else               state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_DONE;
`ifdef ALU_SEQ_MUL_EN
            ST_MUL:  if (mul_last) state_d = ST_DONE;
`endif
            ST_DONE: if (resp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; ALU pins are zero except while a pass is in flight.
    always_comb begin
        opcode_d     = opcode_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        carry_d      = carry_q;
        zero_d       = zero_q;
        alu_a_d      = '0;
        alu_b_d      = '0;
        ctrl_d       = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    opcode_d    = req_opcode_i;
                    if (req_rsvd) begin
                        resp_valid_d = 1'b1;
                        result_d     = '0;
                        carry_d      = 1'b0;
                        zero_d       = 1'b1;
                    end else begin
                        alu_a_d = req_mul ? '0 : req_a_i;
                        alu_b_d = req_mul ? req_a_i : req_b_i;
                        ctrl_d  = req_ctrl;
                    end
                end
            end
            ST_EXEC: begin
                resp_valid_d = 1'b1;
                result_d     = alu_result_i;
                carry_d      = has_carry(opcode_q) & alu_carry_out_i;
                zero_d       = (alu_result_i == '0);
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                if (mul_last) begin
                    resp_valid_d = 1'b1;
                    result_d     = p_d;
                    carry_d      = 1'b0;
                    zero_d       = (p_d == '0);
                end else begin
                    alu_a_d = p_d;
                    alu_b_d = m_d;
                    ctrl_d  = ctrl_q;
                end
            end
`endif
            ST_DONE: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            opcode_q     <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            ctrl_q       <= '0;
        end else begin
            opcode_q     <= opcode_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            carry_q      <= carry_d;
            zero_q       <= zero_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            ctrl_q       <= ctrl_d;
        end
    end

    assign req_ready_o    = req_ready_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_result_o  = result_q;
    assign resp_carry_o   = carry_q;
    assign resp_zero_o    = zero_q;
    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;
    assign alu_a_invert_o = ctrl_q.a_inv;
    assign alu_b_invert_o = ctrl_q.b_inv;
    assign alu_cin_o      = ctrl_q.cin;
    assign alu_op_o       = ctrl_q.op;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle operation sequencer that drives the control and operand pins of the 24-bit ripple ALU and collects its result. It sits between the CPU execute stage and the ALU. It accepts one operation per request handshake and translates the opcode into AInvert/BInvert/CIN/Op settings. Single-pass operations finish in one ALU pass; multiply runs as a 24-step shift-add loop that uses the ALU adder. The result is returned on a valid/ready response channel.

## Interface
- WIDTH, 24, operand and result width.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  sequencer can accept a request (registered).
- ReqOpcode  in  3  operation code.
- ReqA, ReqB  in  WIDTH  operands, sampled at accept.
- RespValid  out  1  result available.
- RespReady  in  1  consumer takes the result.
- RespResult  out  WIDTH  result.
- RespCarry  out  1  ALU carry-out for ADD/SUB/SLT; 0 otherwise.
- RespZero  out  1  RespResult == 0.
- AluA, AluB  out  WIDTH  ALU operands.
- AluAInvert, AluBInvert, AluCin  out  1  ALU controls.
- AluOp  out  2  ALU select: 00 AND, 01 OR, 10 add, 11 Less.
- AluResult  in  WIDTH  ALU result.
- AluCarryOut  in  1  ALU MSB carry-out.

## Operation
- Opcodes and their ALU settings (AInv/BInv/Cin/Op):
  - 000 AND: 0/0/0/00
  - 001 OR: 0/0/0/01
  - 010 ADD: 0/0/0/10
  - 011 SUB: 0/1/1/10
  - 100 SLT: 0/1/1/11
  - 101 NOR: 1/1/0/00
  - 110 MUL: per-step 0/0/0/10
  - 111 reserved
- States:
  - IDLE: ReqReady=1. On ReqValid, latch the opcode and operands. Go to MUL if the opcode is MUL, else EXEC.
  - EXEC: drive the ALU for one cycle. At the next edge, capture AluResult (and AluCarryOut where applicable) and go to DONE.
  - MUL: registers P=0, M=ReqA, Q=ReqB, count=0. Each cycle drive AluA=P, AluB=M.
    - At the edge: if Q[0], P<=AluResult.
    - M<<=1, Q>>=1, count++.
    - After exactly WIDTH steps go to DONE with RespResult=P, truncated to the low WIDTH bits.
    - No early exit.
  - DONE: RespValid=1. On RespReady go to IDLE.
- Outside EXEC/MUL, all Alu* outputs are 0.
- Reserved opcode: no ALU pass. Go straight to DONE with result 0, carry 0, zero 1.
- RespResult/RespCarry/RespZero hold stable while RespValid=1 and RespReady=0.
- ReqValid is ignored whenever ReqReady=0.

## Timing
- Reset values: ReqReady=0, RespValid=0, RespResult=0, RespCarry=0, RespZero=0, all Alu*=0, state IDLE.
- ReqReady rises on the first edge after Reset deasserts.
- ReqReady falls on the accept edge. It rises on the edge that completes the response handshake.
- Latency, counted from the accept edge to RespValid high:
  - single-pass: 2 edges
  - reserved: 1 edge
  - MUL: WIDTH+1 edges (25)
- Minimum request spacing is latency+1 edges. Requests are never overlapped.
- Reset asserted mid-operation: all state and outputs clear immediately and the in-flight operation is discarded. No response is produced.
- The ALU path is combinational within one cycle. The sequencer assumes the 24-bit ripple ALU settles within one Clock period.

## Configuration
- ALU_SEQ_MUL_EN defined: opcode 110 executes the shift-add multiply; P/M/Q/count registers and the MUL state exist.
- Undefined: opcode 110 is handled as reserved (result 0, zero 1, 1-edge latency). The multiply registers and state are not built.

## Structure
- Package alu_seq_pkg:
  - opcode localparams
  - ALU Op encodings (AND/OR/ADD/LESS)
  - state encoding (IDLE/EXEC/MUL/DONE)
  - WIDTH default
- Sub-module alu_ctrl_decode: combinational opcode -> {AInvert, BInvert, CIN, Op} per the table above. It is instantiated once in alu_sequencer.
- The bench pairs alu_sequencer with a 24-bit chain of ALU_1BIT-based slices as the ALU model.

## Test plan
- ADD 0xFFFFFF + 0x000001 -> RespResult 0x000000, RespCarry 1, RespZero 1; RespValid exactly 2 edges after accept.
- SUB 5 - 7 -> ALU pins 0/1/1/10 during EXEC; RespResult 0xFFFFFE, RespCarry 0, RespZero 0.
- SLT 3,5 -> RespResult 0x000001. SLT 5,3 -> 0x000000, RespZero 1. NOR 0,0 -> 0xFFFFFF.
- MUL 0x001234 × 0x000100 -> 0x123400 after 25 edges. MUL 0x800000 × 2 -> 0x000000, RespZero 1.
- Backpressure: RespReady low for 5 cycles -> result stable, ReqReady 0, concurrent ReqValid with ADD 1+1 ignored. After the handshake, ReqReady 1 and the next ADD 1+1 -> 2.
- Reset asserted at MUL step 10 -> all outputs 0 at once. ReqReady 1 one edge after release. Subsequent ADD 2+3 -> 5. With ALU_SEQ_MUL_EN undefined, opcode 110 -> result 0 after 1 edge.
